// File: rtl/base_wrr_arb.sv
// Weighted round-robin arbiter with transaction lock: each requester may keep the
// grant for up to its weight in transactions, and multi-beat transactions are never split.
module base_wrr_arb #(
    parameter int ways   = 4,
    parameter int wwidth = 4,
    parameter int iwidth = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:ways-1]          i_v,
    output logic [0:ways-1]          i_r,
    input  logic [0:ways-1]          i_h,
    input  logic [0:ways*wwidth-1]   cfg_wt,
    output logic                     o_v,
    input  logic                     o_r,
    output logic [0:ways-1]          o_s,
    output logic                     o_h,
    output logic [0:iwidth-1]        o_own
);

    logic [iwidth-1:0] own;
    logic [wwidth-1:0] cnt;
    logic              lock;

    logic [iwidth-1:0] sel;
    logic [iwidth-1:0] cand;
    logic              rot;
    logic              found;
    logic              act;
    logic [wwidth-1:0] cnt_nxt;
    logic [wwidth-1:0] wts [ways];

    // A zero weight still earns one transaction per turn.
    function automatic logic [wwidth-1:0] wt_floor(input logic [wwidth-1:0] w);
        return (w == '0) ? wwidth'(1) : w;
    endfunction

    function automatic logic [wwidth-1:0] sat_dec(input logic [wwidth-1:0] c, input logic d);
        return (d && c != '0) ? c - wwidth'(1) : c;
    endfunction

    always_comb begin
        for (int i = 0; i < ways; i++) begin
            wts[i] = cfg_wt[i*wwidth +: wwidth];
        end
    end

    always_comb begin
        sel   = own;
        rot   = 1'b0;
        found = 1'b0;
        cand  = own;
        o_v   = 1'b0;
        if (lock) begin
            o_v = i_v[own];
        end else if (i_v[own] && cnt != '0) begin
            o_v = 1'b1;
        end else begin
            rot = 1'b1;
            o_v = |i_v;
            // Scan starts just past the owner so the owner itself is considered last.
            for (int k = 1; k <= ways; k++) begin
                cand = iwidth'((int'(own) + k) % ways);
                if (!found && i_v[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_s      = '0;
        o_s[sel] = o_v;
    end

    assign i_r   = o_s & {ways{o_r}};
    assign o_h   = i_h[sel] & o_v;
    assign act   = o_v & o_r;
    assign o_own = own;

    // Credit is charged only on the last beat of a transaction.
    assign cnt_nxt = rot ? sat_dec(wt_floor(wts[sel]), ~i_h[sel])
                         : sat_dec(cnt, ~i_h[sel]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own  <= iwidth'(ways - 1);
            cnt  <= '0;
            lock <= 1'b0;
        end else if (act) begin
            own  <= sel;
            lock <= i_h[sel];
            cnt  <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_base_wrr_arb.sv
// Bench for base_wrr_arb: per-beat expectations are queued as stimulus is applied
// and compared when the arbiter outputs are sampled.
module tb_base_wrr_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:3]  i_v;
    logic [0:3]  i_r;
    logic [0:3]  i_h;
    logic [0:15] cfg_wt;
    logic        o_v;
    logic        o_r;
    logic [0:3]  o_s;
    logic        o_h;
    logic [0:1]  o_own;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [3:0] s;
        logic [1:0] own;
    } exp_t;

    exp_t sb[$];

    base_wrr_arb #(.ways(4), .wwidth(4), .iwidth(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_v    (i_v),
        .i_r    (i_r),
        .i_h    (i_h),
        .cfg_wt (cfg_wt),
        .o_v    (o_v),
        .o_r    (o_r),
        .o_s    (o_s),
        .o_h    (o_h),
        .o_own  (o_own)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        reset = 1'b1;
        i_v   = 4'b0000;
        i_h   = 4'b0000;
        o_r   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst.own", 32'(o_own), 32'd3);
        chk("rst.ov", 32'(o_v), 32'd0);
    endtask

    // Apply one cycle of stimulus; es is the expected one-hot grant, eown the owner after the edge.
    task automatic beat(input string tag, input logic [3:0] v, input logic [3:0] h,
                        input logic r, input logic [3:0] es, input logic [1:0] eown);
        exp_t e;
        i_v = v;
        i_h = h;
        o_r = r;
        sb.push_back('{tag, es, eown});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".s"}, 32'(o_s), 32'(e.s));
        chk({e.tag, ".r"}, 32'(i_r), 32'(e.s & {4{r}}));
        chk({e.tag, ".v"}, 32'(o_v), 32'(|e.s));
        chk({e.tag, ".h"}, 32'(o_h), 32'(|(e.s & h)));
        @(posedge clk);
        #1;
        chk({e.tag, ".own"}, 32'(o_own), 32'(e.own));
    endtask

    initial begin
        reset  = 1'b1;
        i_v    = '0;
        i_h    = '0;
        o_r    = 1'b0;
        cfg_wt = {4'd1, 4'd1, 4'd1, 4'd1};
        #1;

        // Equal weights: plain round robin starting at requester 0.
        do_reset();
        beat("rr0", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("rr1", 4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd1);
        beat("rr2", 4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd2);
        beat("rr3", 4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd3);
        beat("rr4", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);

        // Weights 3,1,2,1.
        cfg_wt = {4'd3, 4'd1, 4'd2, 4'd1};
        do_reset();
        beat("w0", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("w1", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("w2", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("w3", 4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd1);
        beat("w4", 4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd2);
        beat("w5", 4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd2);
        beat("w6", 4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd3);
        beat("w7", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);

        // Dropping valid with credit left rotates immediately and forfeits the credit.
        do_reset();
        beat("drop0", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("drop1", 4'b0111, 4'b0000, 1'b1, 4'b0100, 2'd1);
        beat("drop2", 4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd2);

        // Four-beat locked transaction on requester 1, with a bubble inside it.
        cfg_wt = {4'd1, 4'd1, 4'd1, 4'd1};
        do_reset();
        beat("lk0", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("lk1", 4'b1111, 4'b0100, 1'b1, 4'b0100, 2'd1);
        beat("lk2", 4'b1111, 4'b0100, 1'b1, 4'b0100, 2'd1);
        beat("lkb", 4'b1011, 4'b0100, 1'b1, 4'b0000, 2'd1);
        beat("lk3", 4'b1111, 4'b0100, 1'b1, 4'b0100, 2'd1);
        beat("lk4", 4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd1);
        beat("lk5", 4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd2);

        // Backpressure: grant stable, no state change until o_r rises.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            beat($sformatf("st%0d", i), 4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3);
        end
        beat("st5", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("st6", 4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd1);

        // Lone requester 2 with weight 2 reloads its credit when re-granted to itself.
        cfg_wt = {4'd1, 4'd1, 4'd2, 4'd1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            beat($sformatf("solo%0d", i), 4'b0010, 4'b0000, 1'b1, 4'b0010, 2'd2);
        end
        beat("solo5", 4'b1010, 4'b0000, 1'b1, 4'b0010, 2'd2);
        beat("solo6", 4'b1010, 4'b0000, 1'b1, 4'b1000, 2'd0);

        // Weight 0 behaves as weight 1.
        cfg_wt = {4'd0, 4'd1, 4'd1, 4'd1};
        do_reset();
        beat("wz0", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("wz1", 4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd1);

        // Reset arriving mid-lock releases it; requester 0 wins first.
        cfg_wt = {4'd1, 4'd1, 4'd1, 4'd1};
        do_reset();
        beat("rl0", 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd3);
        beat("rl1", 4'b1111, 4'b0001, 1'b1, 4'b0001, 2'd3);
        i_h   = 4'b0000;
        reset = 1'b1;
        #2;
        chk("rl.own", 32'(o_own), 32'd3);
        chk("rl.s", 32'(o_s), 32'(4'b1000));
        reset = 1'b0;
        beat("rl2", 4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd0);
        beat("rl3", 4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
